dmem_arbiter: RTL and testbench

- Shares the single-port 64x32 data memory between two requesters.
  - Port 0: core load/store unit.
  - Port 1: debug/DMA loader.
- Each port uses a valid/ready request channel and a valid/ready response channel.
- Round-robin or fixed-priority grant, one transaction in flight at a time.
- Owns the memory's addr, data_in and write_enable pins. Registers the combinational read data into a held response.

---
 rtl/dmem_arb_pkg.sv | 22 ++
 rtl/dmem_arbiter_if.sv | 27 ++
 rtl/dmem_arbiter_rr_arb2.sv | 40 ++++
 rtl/dmem_arbiter.sv | 114 +++++++++++
 tb/tb_dmem_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: state encoding, port indices
// and default bus widths.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DMA  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  // One-hot per-port mask for a port index
  function automatic logic [1:0] port_mask(input logic idx);
    return (idx == PORT_DMA) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response channels of the two requesters sharing the data memory;
// bit/slice i belongs to port i.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          req_we;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_ready;
  logic [DATA_W-1:0]   rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way grant: round-robin against the previous winner, or
// fixed priority to port 0 when FIXED_PRIO is set.
module rr_arb2 #(
  parameter int FIXED_PRIO = 0
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // Pick the winner; a tie goes to port 0 or to the port that lost last time
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = 1'b0;
    case (req)
      2'b01: begin
        gnt_valid = 1'b1;
        gnt_idx   = 1'b0;
      end
      2'b10: begin
        gnt_valid = 1'b1;
        gnt_idx   = 1'b1;
      end
      2'b11: begin
        gnt_valid = 1'b1;
        if (FIXED_PRIO != 0) begin
          gnt_idx = 1'b0;
        end else begin
          gnt_idx = ~last_grant;
        end
      end
      default: begin
        gnt_valid = 1'b0;
        gnt_idx   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core LSU (port 0) and the
// debug/DMA loader (port 1); one transaction in flight, IDLE -> ACCESS -> RESP.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_arbiter_if.slave     bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_data_out
);

  arb_state_e        state_r, state_s;
  logic              owner_r;
  logic              last_grant_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rdata_r;
  logic [1:0]        rsp_valid_r;
  logic              gnt_valid_s;
  logic              gnt_idx_s;
  logic [1:0]        req_ready_s;
  logic              req_hs_s;
  logic              rsp_hs_s;

  rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .req        (bus.req_valid),
    .last_grant (last_grant_r),
    .gnt_valid  (gnt_valid_s),
    .gnt_idx    (gnt_idx_s)
  );

  // Offer the grant only in IDLE and never while reset is held
  always_comb begin
    req_ready_s = 2'b00;
    if (rst_n && (state_r == IDLE) && gnt_valid_s) begin
      req_ready_s = port_mask(gnt_idx_s);
    end else begin
      req_ready_s = 2'b00;
    end
  end

  assign req_hs_s = |(bus.req_valid & req_ready_s);
  assign rsp_hs_s = (state_r == RESP) && bus.rsp_ready[owner_r];

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_hs_s) begin
          state_s = ACCESS;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: state_s = RESP;
      RESP: begin
        if (rsp_hs_s) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, request latch and held response; reset discards any in-flight access
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      owner_r      <= 1'b0;
      last_grant_r <= 1'b1;
      we_r         <= 1'b0;
      addr_r       <= {ADDR_W{1'b0}};
      wdata_r      <= {DATA_W{1'b0}};
      rdata_r      <= {DATA_W{1'b0}};
      rsp_valid_r  <= 2'b00;
    end else begin
      state_r <= state_s;
      if (req_hs_s) begin
        owner_r      <= gnt_idx_s;
        last_grant_r <= gnt_idx_s;
        we_r         <= bus.req_we[gnt_idx_s];
        addr_r       <= gnt_idx_s ? bus.req_addr[2*ADDR_W-1:ADDR_W] : bus.req_addr[ADDR_W-1:0];
        wdata_r      <= gnt_idx_s ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
      end
      if (state_r == ACCESS) begin
        rdata_r     <= we_r ? {DATA_W{1'b0}} : mem_data_out;
        rsp_valid_r <= port_mask(owner_r);
      end else if (rsp_hs_s) begin
        rsp_valid_r <= 2'b00;
      end
    end
  end

  // Address/data hold between accesses; the write strobe is also gated by rst_n
  // so a reset landing on the ACCESS cycle cannot commit the write.
  assign mem_addr      = addr_r;
  assign mem_data_in   = wdata_r;
  assign mem_we        = rst_n && (state_r == ACCESS) && we_r;
  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin and a fixed-priority instance, each with
// its own memory, checked cycle by cycle against a transaction-level model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    req_valid [2];
  logic [1:0]    req_we    [2];
  logic [2*AW-1:0] req_addr  [2];
  logic [2*DW-1:0] req_wdata [2];
  logic [1:0]    rsp_ready [2];
  logic [1:0]    req_ready [2];
  logic [1:0]    rsp_valid [2];
  logic [DW-1:0] rsp_rdata [2];
  logic [AW-1:0] mem_addr  [2];
  logic [DW-1:0] mem_data_in  [2];
  logic [DW-1:0] mem_data_out [2];
  logic          mem_we    [2];
  logic [DW-1:0] mem [2][DEPTH];
  logic          loaded = 1'b0;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  assign bus0.req_valid = req_valid[0];
  assign bus0.req_we    = req_we[0];
  assign bus0.req_addr  = req_addr[0];
  assign bus0.req_wdata = req_wdata[0];
  assign bus0.rsp_ready = rsp_ready[0];
  assign req_ready[0]   = bus0.req_ready;
  assign rsp_valid[0]   = bus0.rsp_valid;
  assign rsp_rdata[0]   = bus0.rsp_rdata;
  assign bus1.req_valid = req_valid[1];
  assign bus1.req_we    = req_we[1];
  assign bus1.req_addr  = req_addr[1];
  assign bus1.req_wdata = req_wdata[1];
  assign bus1.rsp_ready = rsp_ready[1];
  assign req_ready[1]   = bus1.req_ready;
  assign rsp_valid[1]   = bus1.rsp_valid;
  assign rsp_rdata[1]   = bus1.rsp_rdata;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .mem_addr(mem_addr[0]), .mem_data_in(mem_data_in[0]), .mem_we(mem_we[0]),
    .mem_data_out(mem_data_out[0])
  );

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .mem_addr(mem_addr[1]), .mem_data_in(mem_data_in[1]), .mem_we(mem_we[1]),
    .mem_data_out(mem_data_out[1])
  );

  function automatic logic [DW-1:0] seed_word(input int i);
    return 32'hC0DE_0000 + (32'(i) * 32'h0000_0101);
  endfunction

  // Behavioural single-port memories, preloaded on the first edge
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[0][i] <= seed_word(i);
        mem[1][i] <= seed_word(i);
      end
      loaded <= 1'b1;
    end else begin
      if (mem_we[0]) mem[0][mem_addr[0]] <= mem_data_in[0];
      if (mem_we[1]) mem[1][mem_addr[1]] <= mem_data_in[1];
    end
  end
  assign mem_data_out[0] = mem[0][mem_addr[0]];
  assign mem_data_out[1] = mem[1][mem_addr[1]];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction-level reference: one pending transaction per instance
  bit            busy   [2];
  int            age    [2];
  logic          m_port [2];
  logic          m_we   [2];
  logic          last   [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wdata[2];
  logic [DW-1:0] m_exp  [2];
  logic [DW-1:0] ref_mem[2][DEPTH];

  function automatic logic pick(input logic [1:0] v, input logic lastg, input bit fp);
    if (v == 2'b01) return 1'b0;
    if (v == 2'b10) return 1'b1;
    if (fp) return 1'b0;
    return !lastg;
  endfunction

  task automatic model_step(input int k);
    logic [1:0] exp_rdy;
    logic p;
    int pi;
    if (!rst_n) begin
      chk("rst_rdy", 64'(req_ready[k]), 64'd0);
      chk("rst_we", 64'(mem_we[k]), 64'd0);
      busy[k] = 1'b0;
      last[k] = 1'b1;
    end else if (busy[k] && age[k] == 0) begin
      chk("acc_rdy", 64'(req_ready[k]), 64'd0);
      chk("acc_we", 64'(mem_we[k]), 64'(m_we[k]));
      chk("acc_addr", 64'(mem_addr[k]), 64'(m_addr[k]));
      chk("acc_rv", 64'(rsp_valid[k]), 64'd0);
      if (m_we[k]) begin
        chk("acc_wd", 64'(mem_data_in[k]), 64'(m_wdata[k]));
        ref_mem[k][m_addr[k]] = m_wdata[k];
      end
      age[k] = 1;
    end else if (busy[k]) begin
      chk("rsp_rdy", 64'(req_ready[k]), 64'd0);
      chk("rsp_we", 64'(mem_we[k]), 64'd0);
      chk("rsp_v", 64'(rsp_valid[k]), m_port[k] ? 64'd2 : 64'd1);
      chk("rsp_d", 64'(rsp_rdata[k]), 64'(m_exp[k]));
      if (rsp_ready[k][m_port[k]]) busy[k] = 1'b0;
    end else begin
      exp_rdy = 2'b00;
      p = 1'b0;
      if (req_valid[k] != 2'b00) begin
        p = pick(req_valid[k], last[k], k == 1);
        exp_rdy = p ? 2'b10 : 2'b01;
      end
      chk("idle_rdy", 64'(req_ready[k]), 64'(exp_rdy));
      chk("idle_rv", 64'(rsp_valid[k]), 64'd0);
      chk("idle_we", 64'(mem_we[k]), 64'd0);
      if (req_valid[k] != 2'b00) begin
        pi = p ? 1 : 0;
        busy[k]    = 1'b1;
        age[k]     = 0;
        m_port[k]  = p;
        last[k]    = p;
        m_we[k]    = req_we[k][pi];
        m_addr[k]  = req_addr[k][pi*AW +: AW];
        m_wdata[k] = req_wdata[k][pi*DW +: DW];
        m_exp[k]   = m_we[k] ? 32'h0 : ref_mem[k][m_addr[k]];
      end
    end
  endtask

  logic [1:0]    hs_req [2];
  logic [1:0]    hs_rsp [2];
  logic [1:0]    rv_s   [2];
  logic [1:0]    rr_s   [2];
  logic [DW-1:0] rd_s   [2];
  logic          we_s   [2];

  // Sample and check on the falling edge, then drive new inputs just after the rising edge
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      model_step(k);
      hs_req[k] = req_valid[k] & req_ready[k];
      hs_rsp[k] = rsp_valid[k] & rsp_ready[k];
      rv_s[k]   = rsp_valid[k];
      rr_s[k]   = req_ready[k];
      rd_s[k]   = rsp_rdata[k];
      we_s[k]   = mem_we[k];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[k][p] = 1'b1;
    req_we[k][p]    = we;
    req_addr[k][p*AW +: AW]  = a;
    req_wdata[k][p*DW +: DW] = d;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 2'b00;
      rsp_ready[k] = 2'b00;
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("rst_maddr", 64'(mem_addr[k]), 64'd0);
      chk("rst_mdin", 64'(mem_data_in[k]), 64'd0);
      chk("rst_rdata", 64'(rsp_rdata[k]), 64'd0);
      chk("rst_rv", 64'(rsp_valid[k]), 64'd0);
    end
  endtask

  task automatic issue(input int k, input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output logic [DW-1:0] rd, output int lat, output int nwe);
    int t0;
    bit got;
    bit done;
    t0 = 0; got = 1'b0; done = 1'b0; lat = -1; nwe = 0; rd = 32'h0;
    set_req(k, p, we, a, d);
    rsp_ready[k][p] = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      if (we_s[k]) nwe++;
      if (got && lat < 0 && rv_s[k][p]) lat = i - t0;
      if (!got && hs_req[k][p]) begin
        got = 1'b1;
        t0 = i;
        req_valid[k][p] = 1'b0;
      end
      if (hs_rsp[k][p]) begin
        rd = rd_s[k];
        done = 1'b1;
      end
    end
    req_valid[k][p] = 1'b0;
    rsp_ready[k][p] = 1'b0;
    chk("issue_done", 64'(done), 64'd1);
  endtask

  task automatic drain(input int k);
    req_valid[k] = 2'b00;
    rsp_ready[k] = 2'b11;
    repeat (6) tick();
    rsp_ready[k] = 2'b00;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rd;
    int lat, nwe, n;
    logic gl [4];
    bit ok;

    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 2'b00; req_we[k] = 2'b00; req_addr[k] = '0; req_wdata[k] = '0; rsp_ready[k] = 2'b00;
      busy[k] = 1'b0; age[k] = 0; last[k] = 1'b1;
      for (int i = 0; i < DEPTH; i++) ref_mem[k][i] = seed_word(i);
    end
    reset_dut();

    // Single write then read on port 0
    issue(0, 0, 1'b1, 6'h05, 32'hDEADBEEF, rd, lat, nwe);
    chk("wr_rdata", 64'(rd), 64'd0);
    chk("wr_lat", 64'(lat), 64'd2);
    chk("wr_we_cycles", 64'(nwe), 64'd1);
    issue(0, 0, 1'b0, 6'h05, 32'h0, rd, lat, nwe);
    chk("rd_data", 64'(rd), 64'hDEADBEEF);
    chk("rd_lat", 64'(lat), 64'd2);
    chk("rd_we_cycles", 64'(nwe), 64'd0);

    // Round-robin contention from a fresh reset
    reset_dut();
    set_req(0, 0, 1'b0, 6'h01, 32'h0);
    set_req(0, 1, 1'b0, 6'h02, 32'h0);
    rsp_ready[0] = 2'b11;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      tick();
      if (hs_rsp[0][0]) chk("rr_d0", 64'(rd_s[0]), 64'(seed_word(1)));
      if (hs_rsp[0][1]) chk("rr_d1", 64'(rd_s[0]), 64'(seed_word(2)));
      if (hs_req[0] != 2'b00) begin gl[n] = hs_req[0][1]; n++; end
    end
    drain(0);
    chk("rr_count", 64'(n), 64'd4);
    chk("rr_g0", 64'(gl[0]), 64'd0);
    chk("rr_g1", 64'(gl[1]), 64'd1);
    chk("rr_g2", 64'(gl[2]), 64'd0);
    chk("rr_g3", 64'(gl[3]), 64'd1);

    // Fixed-priority contention: port 0 wins until it drops valid
    reset_dut();
    set_req(1, 0, 1'b0, 6'h03, 32'h0);
    set_req(1, 1, 1'b0, 6'h04, 32'h0);
    rsp_ready[1] = 2'b11;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      tick();
      if (hs_rsp[1][0]) chk("fp_d0", 64'(rd_s[1]), 64'(seed_word(3)));
      if (hs_rsp[1][1]) chk("fp_d1", 64'(rd_s[1]), 64'(seed_word(4)));
      if (hs_req[1] != 2'b00) begin gl[n] = hs_req[1][1]; n++; end
      if (n == 3) req_valid[1][0] = 1'b0;
    end
    drain(1);
    chk("fp_count", 64'(n), 64'd4);
    chk("fp_g0", 64'(gl[0]), 64'd0);
    chk("fp_g1", 64'(gl[1]), 64'd0);
    chk("fp_g2", 64'(gl[2]), 64'd0);
    chk("fp_g3", 64'(gl[3]), 64'd1);

    // Response backpressure on port 1 with port 0 waiting
    set_req(0, 1, 1'b0, 6'h07, 32'h0);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin tick(); ok = hs_req[0][1]; end
    chk("bp_acc", 64'(ok), 64'd1);
    req_valid[0][1] = 1'b0;
    set_req(0, 0, 1'b0, 6'h08, 32'h0);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin tick(); ok = rv_s[0][1]; end
    chk("bp_rv_rise", 64'(ok), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_v", 64'(rv_s[0]), 64'd2);
      chk("bp_d", 64'(rd_s[0]), 64'(seed_word(7)));
      chk("bp_rdy", 64'(rr_s[0]), 64'd0);
    end
    rsp_ready[0][1] = 1'b1;
    tick();
    chk("bp_rsp_hs", 64'(hs_rsp[0][1]), 64'd1);
    rsp_ready[0][1] = 1'b0;
    tick();
    chk("bp_gnt0", 64'(hs_req[0]), 64'd1);
    req_valid[0][0] = 1'b0;
    rsp_ready[0][0] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick();
      ok = hs_rsp[0][0];
      if (ok) chk("bp_d0", 64'(rd_s[0]), 64'(seed_word(8)));
    end
    chk("bp_done0", 64'(ok), 64'd1);
    rsp_ready[0] = 2'b00;

    // Reset landing on the ACCESS cycle of a write
    set_req(0, 0, 1'b1, 6'h3F, 32'h12345678);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin tick(); ok = hs_req[0][0]; end
    chk("rm_acc", 64'(ok), 64'd1);
    req_valid[0] = 2'b00;
    rst_n = 1'b0;
    tick();
    chk("rm_we", 64'(we_s[0]), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rm_rv", 64'(rv_s[0]), 64'd0);
      chk("rm_we_after", 64'(we_s[0]), 64'd0);
    end
    issue(0, 0, 1'b0, 6'h3F, 32'h0, rd, lat, nwe);
    chk("rm_old", 64'(rd), 64'(seed_word(63)));

    // Edge addresses: no aliasing between 0 and 63
    issue(0, 1, 1'b1, 6'h00, 32'hA5A5_0001, rd, lat, nwe);
    issue(0, 0, 1'b1, 6'h3F, 32'h5A5A_0002, rd, lat, nwe);
    issue(0, 0, 1'b0, 6'h00, 32'h0, rd, lat, nwe);
    chk("wrap_0", 64'(rd), 64'hA5A5_0001);
    issue(0, 1, 1'b0, 6'h3F, 32'h0, rd, lat, nwe);
    chk("wrap_3f", 64'(rd), 64'h5A5A_0002);

    // Randomised traffic on both instances, with drops, backpressure and rare resets
    for (int k = 0; k < 2; k++) begin req_valid[k] = 2'b00; hs_req[k] = 2'b00; end
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        for (int p = 0; p < 2; p++) begin
          if (hs_req[k][p] || (req_valid[k][p] && $urandom_range(0, 7) == 0)) req_valid[k][p] = 1'b0;
          if (!req_valid[k][p] && $urandom_range(0, 2) == 0)
            set_req(k, p, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom);
        end
        rsp_ready[k] = 2'($urandom_range(0, 3));
      end
      rst_n = ($urandom_range(0, 599) != 0);
      tick();
    end
    rst_n = 1'b1;
    drain(0);
    drain(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
